// File: rtl/sum_result_streamer_if.sv
// Bundles the start/status, result-memory read and pixel stream signals of sum_result_streamer.
// The master side is the streamer. The slave side is the memory, the sink and the controller.
interface sum_result_streamer_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic              start;
  logic              busy;
  logic              done;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr1;
  logic [ADDR_W-1:0] rd_addr2;
  logic [ADDR_W-1:0] rd_addr3;
  logic [ADDR_W-1:0] rd_addr4;
  logic [DATA_W-1:0] rd_data1;
  logic [DATA_W-1:0] rd_data2;
  logic [DATA_W-1:0] rd_data3;
  logic [DATA_W-1:0] rd_data4;
  logic [7:0]        out_data;
  logic              out_valid;
  logic              out_ready;

  modport master (
    input  start,
    output busy, done,
    output rd_en, rd_addr1, rd_addr2, rd_addr3, rd_addr4,
    input  rd_data1, rd_data2, rd_data3, rd_data4,
    output out_data, out_valid,
    input  out_ready
  );

  modport slave (
    output start,
    input  busy, done,
    input  rd_en, rd_addr1, rd_addr2, rd_addr3, rd_addr4,
    output rd_data1, rd_data2, rd_data3, rd_data4,
    input  out_data, out_valid,
    output out_ready
  );
endinterface

// File: rtl/sum_result_streamer.sv
// Walks the sum-result memory four words per read and saturates each signed sum to an 8-bit pixel.
// The pixels are streamed one per valid/ready beat.
module sum_result_streamer #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int NUM_WORDS = 65536,
  parameter int BASE_ADDR = 0,
  parameter int RD_LAT    = 1
) (
  input logic                   clk,
  input logic                   rst,
  sum_result_streamer_if.master bus
);

  // Extra headroom so wc+3 lane indices never overflow the counter width.
  localparam int CW = $clog2(NUM_WORDS + 4) + 1;
  localparam int LW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_READ   = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_EMIT   = 3'd3;
  localparam logic [2:0] S_FINISH = 3'd4;

  localparam logic [CW-1:0]     NUM_W  = CW'(NUM_WORDS);
  localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(BASE_ADDR);

  logic [2:0]        r_state;
  logic [CW-1:0]     r_wc;
  logic [LW-1:0]     r_waitCnt;
  logic [1:0]        r_idx;
  logic [DATA_W-1:0] r_buf  [4];
  logic [ADDR_W-1:0] r_addr [4];

  logic [CW-1:0] w_remain;
  logic [2:0]    w_nv;
  logic          w_lastLane;
  logic          w_xfer;
  logic [CW-1:0] w_wcNext;

  function automatic logic [7:0] sat(input logic [DATA_W-1:0] x);
    if (x[DATA_W-1])
      return 8'd0;
    else if (|x[DATA_W-2:8])
      return 8'hFF;
    else
      return x[7:0];
  endfunction

  always_comb begin
    w_remain   = NUM_W - r_wc;
    w_nv       = (w_remain >= CW'(4)) ? 3'd4 : w_remain[2:0];
    w_lastLane = ({1'b0, r_idx} == (w_nv - 3'd1));
    w_xfer     = (r_state == S_EMIT) && bus.out_ready;
    w_wcNext   = r_wc + CW'(w_nv);
  end

  assign bus.busy      = (r_state != S_IDLE);
  assign bus.done      = (r_state == S_FINISH);
  assign bus.rd_en     = (r_state == S_READ);
  assign bus.rd_addr1  = r_addr[0];
  assign bus.rd_addr2  = r_addr[1];
  assign bus.rd_addr3  = r_addr[2];
  assign bus.rd_addr4  = r_addr[3];
  assign bus.out_valid = (r_state == S_EMIT);
  assign bus.out_data  = (r_state == S_EMIT) ? sat(r_buf[r_idx]) : 8'd0;

  // Addresses are loaded on entry to READ and held through WAIT, so memory sees stable lanes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_wc      <= '0;
      r_waitCnt <= '0;
      r_idx     <= '0;
      for (int k = 0; k < 4; k++) begin
        r_buf[k]  <= '0;
        r_addr[k] <= '0;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_wc    <= '0;
            r_idx   <= '0;
            for (int k = 0; k < 4; k++)
              r_addr[k] <= BASE_A + ADDR_W'(k);
            r_state <= S_READ;
          end
        end
        S_READ: begin
          r_waitCnt <= LW'(RD_LAT - 1);
          r_state   <= S_WAIT;
        end
        S_WAIT: begin
          if (r_waitCnt == '0) begin
            r_buf[0] <= bus.rd_data1;
            r_buf[1] <= bus.rd_data2;
            r_buf[2] <= bus.rd_data3;
            r_buf[3] <= bus.rd_data4;
            r_idx    <= '0;
            r_state  <= S_EMIT;
          end else begin
            r_waitCnt <= r_waitCnt - LW'(1);
          end
        end
        S_EMIT: begin
          if (w_xfer) begin
            if (w_lastLane) begin
              r_wc  <= w_wcNext;
              r_idx <= '0;
              if (w_wcNext == NUM_W) begin
                r_state <= S_FINISH;
              end else begin
                for (int k = 0; k < 4; k++)
                  r_addr[k] <= BASE_A + ADDR_W'(w_wcNext) + ADDR_W'(k);
                r_state <= S_READ;
              end
            end else begin
              r_idx <= r_idx + 2'd1;
            end
          end
        end
        S_FINISH: r_state <= S_IDLE;
        default:  r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sum_result_streamer.sv
// Directed bench for sum_result_streamer: two instances (8 words / latency 1 / base 0 and
// 6 words / latency 3 / base 16) against small behavioural memories.
module tb_sum_result_streamer;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic ready = 1'b1;
  logic sel = 1'b0;

  int nCompared = 0;
  int nFailed   = 0;

  logic [31:0] memA [64];
  logic [31:0] memB [64];
  logic [31:0] pA  [4];
  logic [31:0] pB1 [4];
  logic [31:0] pB2 [4];
  logic [31:0] pB3 [4];

  logic [31:0] expData [$];
  logic [31:0] expRdCyc [$];
  logic [31:0] expA1 [$];
  logic [31:0] expA4 [$];

  logic        obsValid, obsBusy, obsDone, obsRdEn;
  logic [7:0]  obsData;
  logic [31:0] obsA1, obsA4;

  sum_result_streamer_if #(.DATA_W(32), .ADDR_W(32)) busA ();
  sum_result_streamer_if #(.DATA_W(32), .ADDR_W(32)) busB ();

  sum_result_streamer #(
    .DATA_W(32), .ADDR_W(32), .NUM_WORDS(8), .BASE_ADDR(0), .RD_LAT(1)
  ) dutA (
    .clk (clk),
    .rst (rst),
    .bus (busA)
  );

  sum_result_streamer #(
    .DATA_W(32), .ADDR_W(32), .NUM_WORDS(6), .BASE_ADDR(16), .RD_LAT(3)
  ) dutB (
    .clk (clk),
    .rst (rst),
    .bus (busB)
  );

  always #5 clk = ~clk;

  assign busA.start     = start && !sel;
  assign busB.start     = start && sel;
  assign busA.out_ready = ready;
  assign busB.out_ready = ready;
  assign busA.rd_data1  = pA[0];
  assign busA.rd_data2  = pA[1];
  assign busA.rd_data3  = pA[2];
  assign busA.rd_data4  = pA[3];
  assign busB.rd_data1  = pB3[0];
  assign busB.rd_data2  = pB3[1];
  assign busB.rd_data3  = pB3[2];
  assign busB.rd_data4  = pB3[3];

  // Memory models: one register stage for A, a three-stage pipe for B.
  always @(posedge clk) begin
    pA[0]  <= memA[busA.rd_addr1[5:0]];
    pA[1]  <= memA[busA.rd_addr2[5:0]];
    pA[2]  <= memA[busA.rd_addr3[5:0]];
    pA[3]  <= memA[busA.rd_addr4[5:0]];
    pB1[0] <= memB[busB.rd_addr1[5:0]];
    pB1[1] <= memB[busB.rd_addr2[5:0]];
    pB1[2] <= memB[busB.rd_addr3[5:0]];
    pB1[3] <= memB[busB.rd_addr4[5:0]];
    pB2    <= pB1;
    pB3    <= pB2;
  end

  always_comb begin
    obsValid = sel ? busB.out_valid : busA.out_valid;
    obsBusy  = sel ? busB.busy      : busA.busy;
    obsDone  = sel ? busB.done      : busA.done;
    obsRdEn  = sel ? busB.rd_en     : busA.rd_en;
    obsData  = sel ? busB.out_data  : busA.out_data;
    obsA1    = sel ? busB.rd_addr1  : busA.rd_addr1;
    obsA4    = sel ? busB.rd_addr4  : busA.rd_addr4;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    nCompared++;
    assert (observed === expected) else begin
      nFailed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_busy"},  {31'd0, obsBusy},  32'd0);
    checkOutput({tag, "_done"},  {31'd0, obsDone},  32'd0);
    checkOutput({tag, "_rden"},  {31'd0, obsRdEn},  32'd0);
    checkOutput({tag, "_valid"}, {31'd0, obsValid}, 32'd0);
    checkOutput({tag, "_data"},  {24'd0, obsData},  32'd0);
    checkOutput({tag, "_addr1"}, obsA1, 32'd0);
    checkOutput({tag, "_addr4"}, obsA4, 32'd0);
  endtask

  // Runs one frame from the current negedge; cycle 1 is the cycle after start is sampled.
  task automatic applyStimulus(input string tag, input logic useB, input int stallFrom,
                               input int stallLen, input int startAgainAt,
                               input int expFirst, input int expDoneCyc);
    logic [31:0] beats [$];
    logic [31:0] rdCyc [$];
    logic [31:0] a1 [$];
    logic [31:0] a4 [$];
    int  first    = -1;
    int  doneCyc  = -1;
    int  nDone    = 0;
    logic finished = 1'b0;
    sel   = useB;
    ready = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 1; cyc <= 200 && !finished; cyc++) begin
      ready = !(cyc >= stallFrom && cyc < stallFrom + stallLen);
      start = (cyc == startAgainAt);
      if (obsValid === 1'b1 && first < 0) first = cyc;
      if (!ready && beats.size() < expData.size()) begin
        checkOutput({tag, "_hold_valid"}, {31'd0, obsValid}, 32'd1);
        checkOutput({tag, "_hold_data"}, {24'd0, obsData}, expData[beats.size()]);
      end
      if (obsValid === 1'b1 && ready) beats.push_back({24'd0, obsData});
      if (obsRdEn === 1'b1) begin
        rdCyc.push_back(32'(cyc));
        a1.push_back(obsA1);
        a4.push_back(obsA4);
      end
      if (obsDone === 1'b1) begin
        nDone++;
        doneCyc = cyc;
      end
      if (obsBusy === 1'b0) finished = 1'b1;
      @(negedge clk);
    end
    start = 1'b0;
    ready = 1'b1;
    checkOutput({tag, "_finished"}, {31'd0, finished}, 32'd1);
    checkOutput({tag, "_first_valid"}, 32'(first), 32'(expFirst));
    checkOutput({tag, "_done_cycle"}, 32'(doneCyc), 32'(expDoneCyc));
    checkOutput({tag, "_done_count"}, 32'(nDone), 32'd1);
    checkOutput({tag, "_beat_count"}, 32'(beats.size()), 32'(expData.size()));
    for (int i = 0; i < expData.size() && i < beats.size(); i++)
      checkOutput($sformatf("%s_beat%0d", tag, i), beats[i], expData[i]);
    checkOutput({tag, "_read_count"}, 32'(rdCyc.size()), 32'(expRdCyc.size()));
    for (int i = 0; i < expRdCyc.size() && i < rdCyc.size(); i++) begin
      checkOutput($sformatf("%s_rd%0d_cycle", tag, i), rdCyc[i], expRdCyc[i]);
      checkOutput($sformatf("%s_rd%0d_addr1", tag, i), a1[i], expA1[i]);
      checkOutput($sformatf("%s_rd%0d_addr4", tag, i), a4[i], expA4[i]);
    end
    for (int i = 0; i < 2; i++) begin
      checkOutput({tag, "_idle_busy"}, {31'd0, obsBusy}, 32'd0);
      @(negedge clk);
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      memA[i] = 32'(i * 1000);
      memB[i] = 32'(i * 1000);
    end
    for (int i = 16; i < 24; i++) memB[i] = 32'(i - 15);

    // Reset state of both instances.
    repeat (2) @(negedge clk);
    sel = 1'b0; #1;
    checkIdleOutputs("rstA");
    sel = 1'b1; #1;
    checkIdleOutputs("rstB");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // A: 8 words 10..80, ready held high.
    for (int i = 0; i < 8; i++) memA[i] = 32'((i + 1) * 10);
    expData  = {32'd10, 32'd20, 32'd30, 32'd40, 32'd50, 32'd60, 32'd70, 32'd80};
    expRdCyc = {32'd1, 32'd7};
    expA1    = {32'd0, 32'd4};
    expA4    = {32'd3, 32'd7};
    applyStimulus("basic", 1'b0, 0, 0, 0, 3, 13);

    // A: saturation corners.
    memA[0] = 32'hFFFF_FFFB;
    memA[1] = 32'd0;
    memA[2] = 32'd255;
    memA[3] = 32'd256;
    memA[4] = 32'h7FFF_FFFF;
    memA[5] = 32'h8000_0000;
    memA[6] = 32'd100;
    memA[7] = 32'h0000_01FF;
    expData = {32'd0, 32'd0, 32'd255, 32'd255, 32'd255, 32'd0, 32'd100, 32'd255};
    applyStimulus("sat", 1'b0, 0, 0, 0, 3, 13);

    // A: 3-cycle stall on the second beat, plus a start pulse while busy.
    for (int i = 0; i < 8; i++) memA[i] = 32'((i + 1) * 10);
    expData  = {32'd10, 32'd20, 32'd30, 32'd40, 32'd50, 32'd60, 32'd70, 32'd80};
    expRdCyc = {32'd1, 32'd10};
    applyStimulus("stall", 1'b0, 4, 3, 5, 3, 16);

    // B: 6 words, latency 3, base 16; second read has only two live lanes.
    expData  = {32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6};
    expRdCyc = {32'd1, 32'd9};
    expA1    = {32'd16, 32'd20};
    expA4    = {32'd19, 32'd23};
    applyStimulus("short", 1'b1, 0, 0, 0, 5, 15);

    // B: reset during the third beat, then a clean restart from the base address.
    sel   = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    checkOutput("abort_pre_valid", {31'd0, obsValid}, 32'd1);
    checkOutput("abort_pre_data", {24'd0, obsData}, 32'd3);
    rst = 1'b0;
    #1;
    checkIdleOutputs("abort");
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checkOutput("abort_no_done", {31'd0, obsDone}, 32'd0);
    end
    rst = 1'b1;
    @(negedge clk);
    applyStimulus("restart", 1'b1, 0, 0, 0, 5, 15);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nFailed);
    $finish;
  end

endmodule
